// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and constants for the FPU normalize/pack path
package fpu_pkg;

    typedef enum logic [1:0] {IDLE, ALIGN, DONE} state_t;

    localparam logic [7:0] EXP_INF    = 8'hFF;
    localparam int         HIDDEN_BIT = 23;
    localparam int         FRAC_W     = 23;
    localparam int         EXP_W      = 8;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp_word_t;

endpackage

// File: rtl/fp_pack.sv
// fp_pack: combinational IEEE-754 single packer with zero/inf/underflow overrides
module fp_pack
    import fpu_pkg::*;
(
    input  logic        sign,
    input  logic [7:0]  exp,
    input  logic [22:0] frac,
    input  logic        selZero,
    input  logic        selInf,
    input  logic        selUnf,
    output logic [31:0] result,
    output logic        zero,
    output logic        ovf,
    output logic        unf
);

    fp_word_t word;
    logic     special;

    assign special = selZero | selInf | selUnf;

    // zero wins over inf, inf over underflow; specials carry an all-zero fraction
    always_comb begin
        word.sign = sign & ~selZero;
        word.exp  = selZero ? 8'h00 : selInf ? EXP_INF : selUnf ? 8'h00 : exp;
        word.frac = special ? '0 : frac;
    end

    assign result = word;
    assign zero   = selZero;
    assign ovf    = selInf & ~selZero;
    assign unf    = selUnf & ~selInf & ~selZero;

endmodule

// File: rtl/fp_normalizer_seq.sv
// fp_normalizer_seq: one-bit-per-cycle normalizer and IEEE-754 single packer
module fp_normalizer_seq
    import fpu_pkg::*;
#(
    parameter int MAG_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [7:0]       in_exp,
    input  logic [MAG_W-1:0] in_mag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_zero,
    output logic             out_ovf,
    output logic             out_unf
);

    state_t           state;
    logic             sgn;
    logic [8:0]       expR;
    logic [MAG_W-1:0] mag;
    logic             isZero, isInf, isUnf, carry, low, finish;
    logic [31:0]      packed_word;
    logic             packZero, packOvf, packUnf;

    // exponent never exceeds 0xFF: right shifts stop as soon as it reaches infinity
    assign isZero = mag == '0;
    assign isInf  = expR == {1'b0, EXP_INF};
    assign isUnf  = expR == 9'd0;
    assign carry  = |mag[MAG_W-1:HIDDEN_BIT+1];
    assign low    = ~mag[HIDDEN_BIT];
    assign finish = isZero | isInf | isUnf | (~carry & ~low);

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    fp_pack u_pack (
        .sign    (sgn),
        .exp     (expR[7:0]),
        .frac    (mag[FRAC_W-1:0]),
        .selZero (isZero),
        .selInf  (isInf),
        .selUnf  (isUnf),
        .result  (packed_word),
        .zero    (packZero),
        .ovf     (packOvf),
        .unf     (packUnf)
    );

    // accept, shift toward bit 23 one position per cycle, then hold the packed result
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sgn        <= 1'b0;
            expR       <= '0;
            mag        <= '0;
            out_result <= '0;
            out_zero   <= 1'b0;
            out_ovf    <= 1'b0;
            out_unf    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    sgn   <= in_sign;
                    expR  <= {1'b0, in_exp};
                    mag   <= in_mag;
                    state <= ALIGN;
                end
                ALIGN: if (finish) begin
                    out_result <= packed_word;
                    out_zero   <= packZero;
                    out_ovf    <= packOvf;
                    out_unf    <= packUnf;
                    state      <= DONE;
                end else if (carry) begin
                    mag  <= mag >> 1;
                    expR <= expR + 9'd1;
                end else begin
                    mag  <= mag << 1;
                    expR <= expR - 9'd1;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_normalizer_seq.sv
// tb_fp_normalizer_seq: scoreboard bench with an arithmetic reference model
module tb_fp_normalizer_seq;

    typedef struct {
        logic [31:0] res;
        logic        z, o, u;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_ready, in_sign = 1'b0;
    logic [7:0]  in_exp = '0;
    logic [31:0] in_mag = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_zero, out_ovf, out_unf;

    int   cyc = 0;
    int   nChecks = 0;
    int   nFails = 0;
    int   readyMode = 2;
    exp_t sb[$];

    fp_normalizer_seq #(.MAG_W(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mag(in_mag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_ovf(out_ovf), .out_unf(out_unf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        nChecks++;
        if (act !== want) begin
            nFails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // count shifts from the leading-one position and the exponent headroom
    function automatic exp_t model(input bit s, input bit [7:0] e, input bit [31:0] m);
        exp_t r;
        int p, sh, n;
        bit [31:0] w;
        r.res = '0; r.z = 0; r.o = 0; r.u = 0; r.acc = 0;
        n = 0; p = 0;
        if (m == 0) r.z = 1;
        else if (e == 8'hFF) begin r.o = 1; r.res = {s, 8'hFF, 23'd0}; end
        else if (e == 0) begin r.u = 1; r.res = {s, 31'd0}; end
        else begin
            for (int i = 0; i < 32; i++) if (m[i]) p = i;
            if (p >= 23) begin
                sh = p - 23;
                if (int'(e) + sh >= 255) begin
                    n = 255 - int'(e); r.o = 1; r.res = {s, 8'hFF, 23'd0};
                end else begin
                    n = sh; w = m >> sh; r.res = {s, 8'(int'(e) + sh), w[22:0]};
                end
            end else begin
                sh = 23 - p;
                if (int'(e) <= sh) begin
                    n = int'(e); r.u = 1; r.res = {s, 31'd0};
                end else begin
                    n = sh; w = m << sh; r.res = {s, 8'(int'(e) - sh), w[22:0]};
                end
            end
        end
        r.lat = n + 1;
        return r;
    endfunction

    task automatic issue(input bit s, input bit [7:0] e, input bit [31:0] m);
        exp_t r;
        int tries = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_sign = s; in_exp = e; in_mag = m;
        while (!in_ready && tries < 200) begin
            @(posedge clk); #1;
            tries++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        r = model(s, e, m);
        r.acc = cyc + 1;
        sb.push_back(r);
        @(posedge clk); #1;
        in_valid = 1'b0; in_sign = 1'($urandom); in_exp = 8'($urandom); in_mag = $urandom;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 400) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic rand_op();
        bit [31:0] m, one;
        bit [7:0]  e;
        int p, k;
        one = 32'd1;
        k = $urandom_range(0, 9);
        p = $urandom_range(0, 31);
        m = (k == 0) ? 32'd0 : (($urandom >> (31 - p)) | (one << p));
        k = $urandom_range(0, 7);
        e = k == 0 ? 8'h00 : k == 1 ? 8'hFF : k == 2 ? 8'($urandom_range(1, 24)) :
            k == 3 ? 8'($urandom_range(246, 254)) : 8'($urandom);
        issue(1'($urandom), e, m);
    endtask

    // consumer side: ready pattern changes just after each edge
    initial forever begin
        @(posedge clk); #1;
        out_ready = readyMode == 0 ? ($urandom_range(0, 3) != 0) : readyMode == 2;
    end

    // monitor: compare the presented result against the scoreboard head every cycle it is valid
    initial begin
        bit prevHeld = 0;
        forever begin
            @(negedge clk);
            if (reset) prevHeld = 0;
            else if (out_valid) begin
                if (sb.size() == 0) chk("unexpected_output", out_result, 32'hx);
                else begin
                    if (!prevHeld) chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                    chk("result", out_result, sb[0].res);
                    chk("flags", {29'd0, out_zero, out_ovf, out_unf}, {29'd0, sb[0].z, sb[0].o, sb[0].u});
                    chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
                    if (out_ready) void'(sb.pop_front());
                end
                prevHeld = !out_ready;
            end else prevHeld = 0;
        end
    end

    initial begin
        int t;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_result", out_result, 32'd0);
        chk("reset_flags", {29'd0, out_zero, out_ovf, out_unf}, 32'd0);

        readyMode = 2;
        issue(0, 8'h80, 32'h0080_0000);
        issue(0, 8'h7F, 32'h0180_0000);
        issue(0, 8'h7F, 32'h0000_0001);
        issue(1, 8'h40, 32'h0000_0000);
        issue(0, 8'hFE, 32'h0100_0000);
        issue(1, 8'h02, 32'h0020_0000);
        issue(1, 8'hFF, 32'h0080_0000);
        issue(0, 8'h00, 32'h0080_0000);
        drain();

        readyMode = 1;
        issue(0, 8'h80, 32'h00C0_0000);
        t = 0;
        while (!out_valid && t < 50) begin @(posedge clk); #1; t++; end
        chk("hold_reached_done", {31'd0, out_valid}, 32'd1);
        repeat (5) begin
            in_valid = 1'b1; in_sign = 1; in_exp = 8'h10; in_mag = $urandom;
            @(posedge clk); #1;
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        readyMode = 2;
        drain();
        repeat (3) @(posedge clk);
        chk("no_spurious_accept", {31'd0, out_valid}, 32'd0);

        issue(0, 8'h7F, 32'h0000_0001);
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midreset_result", out_result, 32'd0);
        issue(0, 8'h7F, 32'h0180_0000);
        drain();

        readyMode = 0;
        repeat (300) rand_op();
        readyMode = 2;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
